dft_frame_loader: RTL and testbench
===================================

// Module: dft_frame_loader
// PURPOSE
// - Upstream bus master for dft_block. Collects an NPTS-sample frame from a valid/ready stream,
//   writes it into dft_block's memory-mapped window, and waits LATENCY cycles for the transform.
// - Then reads the NPTS result bytes back and emits them on an output valid/ready stream.
// - Drives the 8-bit memwrite/adr/writedata bus and consumes memdata, as the processor would.
// PARAMETERS
// - WIDTH     8      sample/result width; must equal dft_block data width
// - NPTS      8      points per frame; BASE_ADR+NPTS-1 must be <= 8'hFF
// - BASE_ADR  8'hF8  first address of the dft_block window
// - LATENCY   4      idle cycles between the last write and the first read (>=1)
// PORTS
// - clk         in   1      system clock, rising edge
// - reset       in   1      asynchronous, active-high reset
// - s_valid     in   1      input sample valid
// - s_ready     out  1      loader accepts a sample this cycle
// - s_data      in   WIDTH  input sample
// - memwrite    out  1      write strobe to dft_block
// - adr         out  8      bus address
// - writedata   out  WIDTH  bus write data
// - memdata     in   WIDTH  bus read data; combinational from adr inside dft_block
// - r_valid     out  1      result valid
// - r_ready     in   1      result consumer ready
// - r_data      out  WIDTH  result byte; index k comes from address BASE_ADR+k
// - frame_done  out  1      one-cycle pulse when the last result of a frame is accepted
// - frame_cnt   out  8      completed frames; wraps 8'hFF -> 8'h00
// BEHAVIOUR
// - All outputs are registered.
// - Reset values: s_ready=0, memwrite=0, adr=BASE_ADR, writedata=0, r_valid=0, r_data=0,
//   frame_done=0, frame_cnt=0; state=FILL, idx=0.
// - FSM states: FILL, WAIT, READ, OUT. idx is a $clog2(NPTS)-bit point index.
// - FILL
//   - s_ready=1. On s_valid&&s_ready, the next cycle drives memwrite=1, adr=BASE_ADR+idx,
//     writedata=s_data. Exactly one write per accepted sample, in order; no write otherwise.
//   - When the sample at idx==NPTS-1 is accepted: idx->0, s_ready drops the next cycle, and the
//     FSM goes to WAIT with counter=LATENCY. That last write still issues in that cycle.
// - WAIT
//   - memwrite=0, s_ready=0. Decrement the counter each cycle; at 1, go to READ.
// - READ
//   - Drive adr=BASE_ADR+idx for one cycle with memwrite=0.
//   - At the end of that cycle, capture memdata into r_data, set r_valid=1, go to OUT.
// - OUT
//   - Hold r_data and r_valid until r_valid&&r_ready.
//   - On the handshake: r_valid=0. If idx<NPTS-1, idx++ and go to READ.
//   - If idx==NPTS-1: idx->0, frame_done=1 for one cycle, frame_cnt++, go to FILL.
// - Throughput: a result is accepted at most every 2 cycles. Frame latency is
//   NPTS + 1 + LATENCY + 2*NPTS cycles with no backpressure.
// - Address arithmetic is 8-bit with no wrap past 8'hFF; out-of-range parameters are an
//   elaboration error.
// - memwrite is never asserted outside FILL. Bus reads and writes never overlap.
// - r_ready while r_valid=0 is ignored. s_valid outside FILL is ignored (s_ready=0, no stall).
// - reset mid-frame: all state clears immediately, memwrite drops asynchronously, and the
//   partial frame is discarded. dft_block contents are not cleared.
// STRUCTURE
// - Shared package dft_pkg:
//   - DFT_BASE_ADR (8'hF8), DFT_NPTS (8)
//   - FSM state localparams FILL=2'd0, WAIT=2'd1, READ=2'd2, OUT=2'd3.
// - Single module; no sub-module. The FSM, idx counter, wait counter and output register are
//   each small.
// TESTING (bench instantiates dft_frame_loader with a behavioural 8x8 RAM model at 8'hF8)
// - Stream 8'hA5..8'hAC with s_valid held high -> 8 consecutive memwrite cycles, adr F8..FF,
//   writedata A5..AC; s_ready low from the cycle after the 8th accept.
// - Same frame, r_ready=1 -> after 4 WAIT cycles, r_data sequence A5..AC.
//   frame_done pulses once with the last result; frame_cnt becomes 1.
// - Toggle s_valid 1,0,1,0 -> writes occur only after accepted samples; addresses stay contiguous.
// - Hold r_ready=0 for 5 cycles at result 3 -> r_valid and r_data (A8) are stable; adr holds FB;
//   no extra reads occur.
// - Assert reset after the 5th sample -> memwrite=0 within the reset cycle. The next frame
//   starts writing at F8, and frame_cnt is unchanged at 0.
// - Run 256 frames -> frame_cnt wraps to 8'h00; frame_done count equals 256.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared constants, FSM encoding and address helper for the dft_block bus master.
package dft_pkg;

    localparam logic [7:0]  DFT_BASE_ADR = 8'hF8;
    localparam int unsigned DFT_NPTS     = 8;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        OUT  = 2'd3
    } loader_state_e;

    // The window never crosses 8'hFF (checked at elaboration), so a plain 8-bit add is exact.
    function automatic logic [7:0] window_adr(input logic [7:0] base, input logic [7:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/dft_frame_loader.sv
// Bus master for dft_block: streams a frame into its window, waits for the transform,
// then reads the results back out onto a valid/ready stream.
module dft_frame_loader
    import dft_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NPTS     = DFT_NPTS,
    parameter logic [7:0]  BASE_ADR = DFT_BASE_ADR,
    parameter int unsigned LATENCY  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             memwrite,
    output logic [7:0]       adr,
    output logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] memdata,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [WIDTH-1:0] r_data,
    output logic             frame_done,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned   IW       = $clog2(NPTS);
    localparam int unsigned   CW       = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPTS - 1);
    localparam logic [CW-1:0] LAT_LOAD = CW'(LATENCY);

    if ((int'(BASE_ADR) + int'(NPTS) - 1 > 255) || (NPTS < 2) || (LATENCY < 1)) begin : g_bad_params
        $error("dft_frame_loader: window exceeds 8'hFF, NPTS < 2 or LATENCY < 1");
    end

    loader_state_e    state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_ready_q, s_ready_d;
    logic             memwrite_q, memwrite_d;
    logic [7:0]       adr_q, adr_d;
    logic [WIDTH-1:0] writedata_q, writedata_d;
    logic             r_valid_q, r_valid_d;
    logic [WIDTH-1:0] r_data_q, r_data_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    always_comb begin
        // NOTE: every _d gets a default before the case, so no branch can leave one unassigned and infer a latch.
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        s_ready_d    = 1'b0;
        memwrite_d   = 1'b0;
        adr_d        = adr_q;
        writedata_d  = writedata_q;
        r_valid_d    = r_valid_q;
        r_data_d     = r_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            FILL: begin
                s_ready_d = 1'b1;
                if (s_valid && s_ready_q) begin
                    memwrite_d  = 1'b1;
                    adr_d       = window_adr(BASE_ADR, 8'(idx_q));
                    writedata_d = s_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d     = '0;
                        cnt_d     = LAT_LOAD;
                        s_ready_d = 1'b0;
                        state_d   = WAIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            WAIT: begin
                // Address is presented on the way into READ so memdata is settled during READ.
                if (cnt_q == CW'(1)) begin
                    adr_d   = window_adr(BASE_ADR, 8'(idx_q));
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            READ: begin
                r_data_d  = memdata;
                r_valid_d = 1'b1;
                state_d   = OUT;
            end

            OUT: begin
                if (r_valid_q && r_ready) begin
                    r_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 1'b1;
                        s_ready_d    = 1'b1;
                        state_d      = FILL;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        adr_d   = window_adr(BASE_ADR, 8'(idx_q + 1'b1));
                        state_d = READ;
                    end
                end
            end

            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            idx_q        <= '0;
            cnt_q        <= '0;
            s_ready_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            adr_q        <= BASE_ADR;
            writedata_q  <= '0;
            r_valid_q    <= 1'b0;
            r_data_q     <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples its peers' pre-edge values.
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            s_ready_q    <= s_ready_d;
            memwrite_q   <= memwrite_d;
            adr_q        <= adr_d;
            writedata_q  <= writedata_d;
            r_valid_q    <= r_valid_d;
            r_data_q     <= r_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign memwrite   = memwrite_q;
    assign adr        = adr_q;
    assign writedata  = writedata_q;
    assign r_valid    = r_valid_q;
    assign r_data     = r_data_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_dft_frame_loader.sv
// Self-checking bench for dft_frame_loader with a behavioural dft_block RAM window.
module tb_dft_frame_loader;
    import dft_pkg::*;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned NPTS    = DFT_NPTS;
    localparam logic [7:0]  BASE    = DFT_BASE_ADR;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned IW      = $clog2(NPTS);
    localparam int          BUDGET  = 200;

    logic             clk = 1'b0;
    logic             reset;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             memwrite;
    logic [7:0]       adr;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] memdata;
    logic             r_valid;
    logic             r_ready;
    logic [WIDTH-1:0] r_data;
    logic             frame_done;
    logic [7:0]       frame_cnt;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         done_cnt = 0;
    logic [7:0] model_cnt = 8'h00;

    logic [7:0] wr_adr_q[$];
    logic [7:0] wr_dat_q[$];
    int         wr_cyc_q[$];

    always #5 clk = ~clk;

    dft_frame_loader #(
        .WIDTH(WIDTH), .NPTS(NPTS), .BASE_ADR(BASE), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .memwrite(memwrite), .adr(adr), .writedata(writedata), .memdata(memdata),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    // dft_block stand-in: plain RAM at the window, transform is identity
    logic [WIDTH-1:0] ram [NPTS];
    always @(posedge clk) begin
        if (memwrite && adr >= BASE) ram[IW'(adr - BASE)] <= writedata;
    end
    assign memdata = (adr >= BASE) ? ram[IW'(adr - BASE)] : '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (memwrite) begin
            wr_adr_q.push_back(adr);
            wr_dat_q.push_back(writedata);
            wr_cyc_q.push_back(cyc);
        end
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset   = 1'b1;
        s_valid = 1'b0;
        r_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        model_cnt = 8'h00;
    endtask

    task automatic push_frame(input logic [7:0] smp [NPTS], input int n, input int idle,
                              input int gap_pct, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int j = 0; j < idle; j++) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            while (int'($urandom_range(99)) < gap_pct) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = smp[i];
            for (int t = 0; !s_ready; t++) begin
                if (t == BUDGET) begin
                    n_tests++; n_fail++;
                    $display("FAIL accept_timeout: sample %0d not accepted, s_ready=%b want 1", i, s_ready);
                    s_valid = 1'b0;
                    ok = 1'b0;
                    return;
                end
                @(negedge clk);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pull_frame(input logic [7:0] exp [NPTS], input int rdy_pct, input int hold_k,
                              output int first_cyc);
        int prev_cyc;
        first_cyc = -1;
        prev_cyc  = 0;
        for (int k = 0; k < NPTS; k++) begin
            @(negedge clk);
            for (int t = 0; !r_valid; t++) begin
                if (t == BUDGET) begin
                    n_tests++; n_fail++;
                    $display("FAIL result_timeout: result %0d r_valid=%b want 1", k, r_valid);
                    r_ready = 1'b0;
                    return;
                end
                r_ready = (int'($urandom_range(99)) < rdy_pct);
                @(negedge clk);
            end
            if (k == 0) first_cyc = cyc;
            else if (rdy_pct == 100 && hold_k < 0) begin
                n_tests++;
                if (cyc - prev_cyc != 2) begin
                    n_fail++;
                    $display("FAIL result_spacing: result %0d got %0d cycles want 2", k, cyc - prev_cyc);
                end
            end
            prev_cyc = cyc;
            n_tests++;
            if (r_data !== exp[k]) begin
                n_fail++;
                $display("FAIL r_data[%0d]: got %h want %h", k, r_data, exp[k]);
            end
            n_tests++;
            if (adr !== 8'(BASE + k)) begin
                n_fail++;
                $display("FAIL read_adr[%0d]: got %h want %h", k, adr, 8'(BASE + k));
            end
            if (k == hold_k) begin
                r_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    n_tests++;
                    if (r_valid !== 1'b1 || r_data !== exp[k] || adr !== 8'(BASE + k)) begin
                        n_fail++;
                        $display("FAIL hold[%0d]: got valid=%b data=%h adr=%h want 1 %h %h",
                                 k, r_valid, r_data, adr, exp[k], 8'(BASE + k));
                    end
                end
            end
            r_ready = (int'($urandom_range(99)) < rdy_pct) || (k == hold_k);
            while (!r_ready) begin
                @(negedge clk);
                n_tests++;
                if (r_valid !== 1'b1 || r_data !== exp[k]) begin
                    n_fail++;
                    $display("FAIL stall[%0d]: got valid=%b data=%h want 1 %h", k, r_valid, r_data, exp[k]);
                end
                r_ready = (int'($urandom_range(99)) < rdy_pct);
            end
        end
        @(negedge clk);
        r_ready = 1'b0;
        s_valid = 1'b0;
        model_cnt = model_cnt + 8'd1;
        n_tests++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_done_pulse: got %b want 1", frame_done);
        end
        n_tests++;
        if (frame_cnt !== model_cnt) begin
            n_fail++;
            $display("FAIL frame_cnt: got %h want %h", frame_cnt, model_cnt);
        end
        @(negedge clk);
        n_tests++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_done_width: got %b want 0", frame_done);
        end
    endtask

    task automatic run_frame(input logic [7:0] smp [NPTS], input int idle, input int gap_pct,
                             input int rdy_pct, input int hold_k, input bit junk_valid);
        bit ok;
        int first_cyc;
        wr_adr_q.delete();
        wr_dat_q.delete();
        wr_cyc_q.delete();
        push_frame(smp, NPTS, idle, gap_pct, ok);
        if (!ok) return;
        n_tests++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL s_ready_after_last: got %b want 0", s_ready);
        end
        @(negedge clk);
        n_tests++;
        if (wr_adr_q.size() != NPTS) begin
            n_fail++;
            $display("FAIL write_count: got %0d want %0d", wr_adr_q.size(), NPTS);
        end
        for (int i = 0; i < NPTS && i < wr_adr_q.size(); i++) begin
            n_tests++;
            if (wr_adr_q[i] !== 8'(BASE + i) || wr_dat_q[i] !== smp[i]) begin
                n_fail++;
                $display("FAIL write[%0d]: got adr=%h data=%h want %h %h",
                         i, wr_adr_q[i], wr_dat_q[i], 8'(BASE + i), smp[i]);
            end
            if (i > 0 && gap_pct == 0) begin
                n_tests++;
                if (wr_cyc_q[i] - wr_cyc_q[i-1] != idle + 1) begin
                    n_fail++;
                    $display("FAIL write_spacing[%0d]: got %0d want %0d",
                             i, wr_cyc_q[i] - wr_cyc_q[i-1], idle + 1);
                end
            end
        end
        if (junk_valid) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
        end
        pull_frame(smp, rdy_pct, hold_k, first_cyc);
        if (first_cyc >= 0 && wr_cyc_q.size() == NPTS) begin
            n_tests++;
            if (first_cyc - wr_cyc_q[NPTS-1] != int'(LATENCY) + 1) begin
                n_fail++;
                $display("FAIL wait_latency: got %0d want %0d",
                         first_cyc - wr_cyc_q[NPTS-1], LATENCY + 1);
            end
        end
        n_tests++;
        if (wr_adr_q.size() != NPTS) begin
            n_fail++;
            $display("FAIL writes_outside_fill: got %0d writes want %0d", wr_adr_q.size(), NPTS);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({s_ready, memwrite, r_valid, frame_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got s_ready,memwrite,r_valid,frame_done=%b want 0000",
                     {s_ready, memwrite, r_valid, frame_done});
        end
        n_tests++;
        if (adr !== BASE) begin
            n_fail++;
            $display("FAIL reset_adr: got %h want %h", adr, BASE);
        end
        n_tests++;
        if (writedata !== 8'h00 || r_data !== 8'h00 || frame_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got wd=%h rd=%h cnt=%h want 00 00 00", writedata, r_data, frame_cnt);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (s_ready !== 1'b1 || memwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got s_ready=%b memwrite=%b want 1 0", s_ready, memwrite);
        end
    endtask

    task automatic test_stream_frame();
        logic [7:0] smp [NPTS];
        int d0;
        for (int i = 0; i < NPTS; i++) smp[i] = 8'(8'hA5 + i);
        d0 = done_cnt;
        run_frame(smp, 0, 0, 100, -1, 1'b0);
        @(negedge clk);
        n_tests++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL done_count_one_frame: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_toggle_valid();
        logic [7:0] smp [NPTS];
        for (int i = 0; i < NPTS; i++) smp[i] = 8'($urandom);
        run_frame(smp, 1, 0, 100, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [7:0] smp [NPTS];
        for (int i = 0; i < NPTS; i++) smp[i] = 8'(8'hA5 + i);
        run_frame(smp, 0, 0, 100, 3, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] smp [NPTS];
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NPTS; i++) smp[i] = 8'($urandom);
            run_frame(smp, 0, 40, 50, -1, 1'b1);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] smp [NPTS];
        bit ok;
        for (int i = 0; i < NPTS; i++) smp[i] = 8'($urandom);
        push_frame(smp, 5, 0, 0, ok);
        if (!ok) return;
        n_tests++;
        if (memwrite !== 1'b1 || adr !== 8'(BASE + 4)) begin
            n_fail++;
            $display("FAIL fifth_write: got memwrite=%b adr=%h want 1 %h", memwrite, adr, 8'(BASE + 4));
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (memwrite !== 1'b0 || adr !== BASE || s_ready !== 1'b0 || frame_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got memwrite=%b adr=%h s_ready=%b cnt=%h want 0 %h 0 00",
                     memwrite, adr, s_ready, frame_cnt, BASE);
        end
        @(negedge clk);
        reset     = 1'b0;
        model_cnt = 8'h00;
        @(negedge clk);
        n_tests++;
        if (frame_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL cnt_after_reset: got %h want 00", frame_cnt);
        end
        for (int i = 0; i < NPTS; i++) smp[i] = 8'($urandom);
        run_frame(smp, 0, 0, 100, -1, 1'b0);
    endtask

    task automatic test_wrap();
        logic [7:0] smp [NPTS];
        int d0;
        apply_reset();
        d0 = done_cnt;
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < NPTS; i++) smp[i] = 8'($urandom);
            run_frame(smp, 0, 0, 100, -1, 1'b0);
            if (f == 254) begin
                n_tests++;
                if (frame_cnt !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL cnt_at_255: got %h want ff", frame_cnt);
                end
            end
        end
        @(negedge clk);
        n_tests++;
        if (frame_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL cnt_wrap: got %h want 00", frame_cnt);
        end
        n_tests++;
        if (done_cnt - d0 != 256) begin
            n_fail++;
            $display("FAIL done_count_256: got %0d want 256", done_cnt - d0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        r_ready = 1'b0;
        test_reset();
        test_stream_frame();
        test_toggle_valid();
        test_backpressure();
        test_random();
        test_reset_midframe();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
